// File: rtl/jdff_sync.sv
// ---------------------------------------------------------------------------
// jdff_sync
// Behavioural timing model of a clocked SFQ D flip-flop. A data pulse on din
// is stored as flux and released on the next clk pulse as a delayed,
// fixed-width pulse on dout. Setup/hold violations and data pulses merged
// into an already stored quantum are counted for statistics.
// Time unit is ps (timescale 1ps/100fs).
//
// Parameters:
//   TDELAY   clk-to-dout delay, ps
//   TSETUP   minimum din-before-clk interval, ps
//   THOLD    minimum clk-before-din interval, ps
//   PULSE_W  output pulse width, ps
//   CNT_W    width of each statistics counter
//
// Ports:
//   clk       in   clock pulse; rising edge is the clock event
//   rst       in   asynchronous active-high reset
//   din       in   data pulse; rising edge is the data event
//   dout      out  output pulse
//   stored    out  flux-stored flag (state == STORED)
//   viol_cnt  out  setup + hold violations, saturating
//   dup_cnt   out  din pulses merged into an already stored state, saturating
//
// Optional feature macro: JDFF_VIOLATION_LOG_EN
//   Defined   - every setup/hold violation prints one line with the time,
//               the violation type and the measured interval in ps.
//   Undefined - silent; counting behaviour is identical.
//
// Note: this is a timing model, not a synthesis target. It schedules output
// pulses with real-valued delays and needs a simulator with timing support.
// ---------------------------------------------------------------------------
`timescale 1ps/100fs

module jdff_sync #(
    parameter real TDELAY  = 5.5,
    parameter real TSETUP  = 1.2,
    parameter real THOLD   = 1.5,
    parameter real PULSE_W = 2.0,
    parameter int  CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic             stored,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] dup_cnt
);

    typedef enum logic {
        EMPTY  = 1'b0,
        STORED = 1'b1
    } state_t;

    // Far enough in the past that the first din can never look like a hold
    // violation against a clock edge that never happened.
    localparam real T_INIT = -1.0e12;

    state_t      r_state;
    real         r_clk_last;
    real         r_din_last;
    logic        r_clk_lvl;
    logic        r_din_lvl;
    // r_rst_gen cancels every pending rise/fall when reset hits;
    // r_pulse_gen lets only the most recently scheduled pulse end dout.
    int unsigned r_rst_gen;
    int unsigned r_pulse_gen;

    assign stored = (r_state == STORED);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    task automatic log_viol(input string kind, input real dt);
`ifdef JDFF_VIOLATION_LOG_EN
        $display("%0t jdff_sync: %s violation, interval %0.3f ps", $realtime, kind, dt);
`else
        if (kind.len() == 0 && dt < 0.0) begin
            // nothing to report when logging is disabled
        end
`endif
    endtask

    // Launch one output pulse. The rise is dropped if a reset intervened;
    // the fall is dropped if a reset intervened or a newer pulse was launched,
    // so overlapping pulses merge and end at the latest pulse's fall time.
    task automatic schedule_pulse();
        int unsigned w_rg;
        int unsigned w_pg;
        r_pulse_gen = r_pulse_gen + 1;
        w_rg        = r_rst_gen;
        w_pg        = r_pulse_gen;
        fork
            begin
                #(TDELAY);
                if (w_rg == r_rst_gen) begin
                    dout = 1'b1;
                end
                #(PULSE_W);
                if (w_rg == r_rst_gen && w_pg == r_pulse_gen) begin
                    dout = 1'b0;
                end
            end
        join_none
    endtask

    // Single event process. Any change on clk, din or rst wakes it; rising
    // edges are found by comparing against the last seen levels so both a
    // din and a clk rising in the same timestep are handled, din first.
    // Blocking updates keep that din-then-clk ordering visible inside one
    // activation.
    always @(clk or din or rst) begin : p_events
        real  w_now;
        logic w_clk_rise;
        logic w_din_rise;

        w_now      = $realtime;
        w_clk_rise = clk && !r_clk_lvl;
        w_din_rise = din && !r_din_lvl;
        r_clk_lvl  = clk;
        r_din_lvl  = din;

        if (rst) begin
            r_rst_gen  = r_rst_gen + 1;
            dout       = 1'b0;
            r_state    = EMPTY;
            viol_cnt   = '0;
            dup_cnt    = '0;
            r_clk_last = T_INIT;
            r_din_last = T_INIT;
        end else begin
            if (w_din_rise) begin
                if (w_now - r_clk_last < THOLD) begin
                    // hold violation: pulse is lost, din_last untouched
                    viol_cnt = sat_inc(viol_cnt);
                    log_viol("hold", w_now - r_clk_last);
                end else if (r_state == EMPTY) begin
                    r_state    = STORED;
                    r_din_last = w_now;
                end else begin
                    dup_cnt    = sat_inc(dup_cnt);
                    r_din_last = w_now;
                end
            end

            if (w_clk_rise) begin
                r_clk_last = w_now;
                if (r_state == STORED) begin
                    if (w_now - r_din_last >= TSETUP) begin
                        schedule_pulse();
                    end else begin
                        viol_cnt = sat_inc(viol_cnt);
                        log_viol("setup", w_now - r_din_last);
                    end
                end
                r_state = EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_jdff_sync.sv
// ---------------------------------------------------------------------------
// tb_jdff_sync
// Directed test of jdff_sync: nominal capture, hold and setup violations,
// merged data pulses, reset cancelling a pending pulse, simultaneous din/clk,
// and counter saturation. Each scenario starts from a reset at a base time.
// ---------------------------------------------------------------------------
`timescale 1ps/100fs

module tb_jdff_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       dout;
    logic       stored;
    logic [7:0] viol_cnt;
    logic [7:0] dup_cnt;

    int  n_cmp  = 0;
    int  n_fail = 0;
    real base   = 0.0;

    jdff_sync #(
        .TDELAY (5.5),
        .TSETUP (1.2),
        .THOLD  (1.5),
        .PULSE_W(2.0),
        .CNT_W  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .dout    (dout),
        .stored  (stored),
        .viol_cnt(viol_cnt),
        .dup_cnt (dup_cnt)
    );

    // Wait until base + t ps.
    task automatic at(input real t);
        real d;
        d = base + t - $realtime;
        if (d > 0.0) #(d);
    endtask

    task automatic pulse_clk();
        clk = 1'b1;
        #0.2;
        clk = 1'b0;
    endtask

    task automatic pulse_din();
        din = 1'b1;
        #0.2;
        din = 1'b0;
    endtask

    task automatic pulse_both();
        din = 1'b1;
        clk = 1'b1;
        #0.2;
        din = 1'b0;
        clk = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $realtime, got, exp);
        end
        $display("check %-18s t=%0t observed=%0d expected=%0d", tag, $realtime, got, exp);
    endtask

    // Reset pulse at base+0..base+1 with a reset-state check inside it.
    task automatic do_reset(input string tag);
        at(0.0);
        rst = 1'b1;
        at(0.5);
        check({tag, "_rst_dout"}, 32'(dout), 32'd0);
        check({tag, "_rst_stored"}, 32'(stored), 32'd0);
        check({tag, "_rst_viol"}, 32'(viol_cnt), 32'd0);
        check({tag, "_rst_dup"}, 32'(dup_cnt), 32'd0);
        at(1.0);
        rst = 1'b0;
    endtask

    initial begin
        // ---- 1: nominal capture, clk 20/40, din 30 ----
        base = 10.0;
        do_reset("t1");
        at(20.0); pulse_clk();
        at(30.0); pulse_din();
        at(35.0); check("t1_stored_hi", 32'(stored), 32'd1);
        at(40.0); pulse_clk();
        at(41.0); check("t1_stored_lo", 32'(stored), 32'd0);
        at(45.3); check("t1_dout_pre", 32'(dout), 32'd0);
        at(45.7); check("t1_dout_rise", 32'(dout), 32'd1);
        at(47.3); check("t1_dout_hold", 32'(dout), 32'd1);
        at(47.7); check("t1_dout_fall", 32'(dout), 32'd0);
        check("t1_viol", 32'(viol_cnt), 32'd0);
        check("t1_dup", 32'(dup_cnt), 32'd0);

        // ---- 2: hold violation, clk 20, din 21, clk 40 ----
        base = 100.0;
        do_reset("t2");
        at(20.0); pulse_clk();
        at(21.0); pulse_din();
        at(22.0); check("t2_stored", 32'(stored), 32'd0);
        check("t2_viol_a", 32'(viol_cnt), 32'd1);
        at(40.0); pulse_clk();
        at(45.7); check("t2_dout", 32'(dout), 32'd0);
        check("t2_viol_b", 32'(viol_cnt), 32'd1);

        // ---- 3: setup violation, din 39.5, clk 40 ----
        base = 200.0;
        do_reset("t3");
        at(39.5); pulse_din();
        at(39.8); check("t3_stored_hi", 32'(stored), 32'd1);
        at(40.0); pulse_clk();
        at(40.5); check("t3_stored_lo", 32'(stored), 32'd0);
        check("t3_viol", 32'(viol_cnt), 32'd1);
        at(45.7); check("t3_dout", 32'(dout), 32'd0);

        // ---- 4: merged data, din 25 and 30, clk 40 ----
        base = 300.0;
        do_reset("t4");
        at(25.0); pulse_din();
        at(30.0); pulse_din();
        at(40.0); pulse_clk();
        at(41.0); check("t4_dup", 32'(dup_cnt), 32'd1);
        check("t4_viol", 32'(viol_cnt), 32'd0);
        at(45.7); check("t4_dout_rise", 32'(dout), 32'd1);
        at(47.7); check("t4_dout_fall", 32'(dout), 32'd0);

        // ---- 5: reset cancels pending pulse ----
        base = 400.0;
        do_reset("t5");
        at(30.0); pulse_din();
        at(35.0); pulse_din();
        at(40.0); pulse_clk();
        at(41.0); check("t5_dup_pre", 32'(dup_cnt), 32'd1);
        at(42.0); rst = 1'b1;
        at(42.5); check("t5_dup_rst", 32'(dup_cnt), 32'd0);
        check("t5_viol_rst", 32'(viol_cnt), 32'd0);
        check("t5_stored_rst", 32'(stored), 32'd0);
        at(43.0); rst = 1'b0;
        at(45.7); check("t5_dout_a", 32'(dout), 32'd0);
        at(47.0); check("t5_dout_b", 32'(dout), 32'd0);
        at(50.0); check("t5_dout_c", 32'(dout), 32'd0);
        at(60.0); pulse_din();
        at(80.0); pulse_clk();
        at(85.3); check("t5_dout_pre", 32'(dout), 32'd0);
        at(85.7); check("t5_dout_rise", 32'(dout), 32'd1);
        at(87.7); check("t5_dout_fall", 32'(dout), 32'd0);

        // ---- 6: simultaneous din/clk, then saturation ----
        base = 600.0;
        do_reset("t6");
        at(40.0); pulse_both();
        at(40.5); check("t6_sim_viol", 32'(viol_cnt), 32'd1);
        check("t6_sim_stored", 32'(stored), 32'd0);
        at(45.7); check("t6_sim_dout", 32'(dout), 32'd0);
        // Each iteration: clk then din 0.5 ps later -> one hold violation.
        for (int i = 0; i < 253; i++) begin
            at(50.0 + 2.0 * i);       pulse_clk();
            at(50.0 + 2.0 * i + 0.5); pulse_din();
        end
        at(50.0 + 2.0 * 253); check("t6_viol_254", 32'(viol_cnt), 32'd254);
        for (int i = 253; i < 300; i++) begin
            at(50.0 + 2.0 * i);       pulse_clk();
            at(50.0 + 2.0 * i + 0.5); pulse_din();
        end
        at(50.0 + 2.0 * 300); check("t6_viol_sat", 32'(viol_cnt), 32'd255);
        check("t6_dup", 32'(dup_cnt), 32'd0);
        check("t6_dout", 32'(dout), 32'd0);

        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
